lbm_dist_pingpong_ram: RTL and testbench

//  Double-buffered LBM distribution store: DEPTH lattice nodes x Q lanes of WORD_W-bit signed f_i.

---
 rtl/lbm_pkg.sv | 12 +
 rtl/lbm_dist_pingpong_ram_if.sv | 31 +++
 rtl/lbm_dist_bank.sv | 40 ++++
 rtl/lbm_dist_pingpong_ram.sv | 148 ++++++++++++++
 tb/tb_lbm_dist_pingpong_ram.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lbm_pkg.sv
// rtl/lbm_pkg.sv - shared lane/word types and FSM states for the LBM distribution store
package lbm_pkg;

   localparam int Q      = 9;
   localparam int WORD_W = 32;

   typedef logic signed [WORD_W-1:0] dist_t;
   typedef dist_t [Q-1:0] node_vec_t;

   typedef enum logic {IDLE, INIT} dist_ram_state_t;

endpackage

// File: rtl/lbm_dist_pingpong_ram_if.sv
// rtl/lbm_dist_pingpong_ram_if.sv - request/response bundle of the ping-pong distribution store
interface lbm_dist_pingpong_ram_if
   import lbm_pkg::*;
#(
   parameter int ADDR_W = 8
);
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   node_vec_t         rd_data;
   logic              rd_valid;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [Q-1:0]      wr_lane_mask;
   node_vec_t         wr_data;
   logic              swap;
   logic              bank_sel;
   logic              init_start;
   node_vec_t         init_data;
   logic              busy;
   logic              addr_err;

   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_lane_mask, wr_data, swap, init_start, init_data,
      input  rd_data, rd_valid, bank_sel, busy, addr_err
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_lane_mask, wr_data, swap, init_start, init_data,
      output rd_data, rd_valid, bank_sel, busy, addr_err
   );
endinterface

// File: rtl/lbm_dist_bank.sv
// rtl/lbm_dist_bank.sv - one DEPTH x Q distribution bank: lane-masked write, registered read
module lbm_dist_bank
   import lbm_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output node_vec_t         rd_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [Q-1:0]      wr_mask,
   input  node_vec_t         wr_data
);

   // Storage is deliberately left unreset; only the read register has a reset value.
   node_vec_t mem [DEPTH];

   always_ff @(posedge Clk) begin
      if (wr_en) begin
         for (int i = 0; i < Q; i++) begin
            if (wr_mask[i]) begin
               mem[wr_addr][i] <= wr_data[i];
            end
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/lbm_dist_pingpong_ram.sv
// rtl/lbm_dist_pingpong_ram.sv - double-buffered LBM distribution store with bank swap
// Optional init sweep enabled by defining LBM_DIST_INIT_EN.
module lbm_dist_pingpong_ram
   import lbm_pkg::*;
#(
   parameter int NX     = 16,
   parameter int NY     = 16,
   parameter int DEPTH  = NX * NY,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input logic                   Clk,
   input logic                   Reset,
   lbm_dist_pingpong_ram_if.slave bus
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   logic              busy;
   logic              init_we;
   logic              init_done;
   logic [ADDR_W-1:0] init_addr;
   node_vec_t         init_vec;

   logic              bank_sel;
   logic              rd_valid_q;
   logic              rd_sel_q;
   logic              rd_oor_q;
   logic              addr_err_q;

   logic rd_ok, wr_ok, rd_fire, wr_fire, swap_fire;

   assign rd_ok     = {1'b0, bus.rd_addr} < DEPTH_L;
   assign wr_ok     = {1'b0, bus.wr_addr} < DEPTH_L;
   assign rd_fire   = bus.rd_en & ~busy;
   assign wr_fire   = bus.wr_en & ~busy;
   assign swap_fire = bus.swap & ~busy;

`ifdef LBM_DIST_INIT_EN
   dist_ram_state_t   state, state_nxt;
   logic [ADDR_W-1:0] cnt;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state    <= IDLE;
         cnt      <= '0;
         init_vec <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && bus.init_start) begin
            cnt      <= '0;
            init_vec <= bus.init_data;
         end else if (state == INIT) begin
            cnt <= cnt + ADDR_W'(1);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      init_done = 1'b0;
      case (state)
         IDLE: if (bus.init_start) state_nxt = INIT;
         INIT: begin
            if (cnt == ADDR_W'(DEPTH - 1)) begin
               state_nxt = IDLE;
               init_done = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy      = (state == INIT);
   assign init_we   = busy;
   assign init_addr = cnt;
`else
   logic unused_init;
   assign unused_init = ^{bus.init_start, bus.init_data};
   assign busy      = 1'b0;
   assign init_we   = 1'b0;
   assign init_done = 1'b0;
   assign init_addr = '0;
   assign init_vec  = '0;
`endif

   // The init sweep overrides the normal write path and hits both banks at once.
   logic [ADDR_W-1:0] wr_addr_m;
   logic [Q-1:0]      wr_mask_m;
   node_vec_t         wr_data_m;
   logic [1:0]        b_rd_en;
   logic [1:0]        b_wr_en;
   node_vec_t         b_rd_data [2];

   assign wr_addr_m = init_we ? init_addr : bus.wr_addr;
   assign wr_mask_m = init_we ? {Q{1'b1}} : bus.wr_lane_mask;
   assign wr_data_m = init_we ? init_vec : bus.wr_data;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      assign b_rd_en[b] = rd_fire & rd_ok & (bank_sel == 1'(b));
      assign b_wr_en[b] = init_we | (wr_fire & wr_ok & (bank_sel != 1'(b)));

      lbm_dist_bank #(
         .DEPTH  (DEPTH),
         .ADDR_W (ADDR_W)
      ) u_bank (
         .Clk     (Clk),
         .Reset   (Reset),
         .rd_en   (b_rd_en[b]),
         .rd_addr (bus.rd_addr),
         .rd_data (b_rd_data[b]),
         .wr_en   (b_wr_en[b]),
         .wr_addr (wr_addr_m),
         .wr_mask (wr_mask_m),
         .wr_data (wr_data_m)
      );
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         bank_sel   <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_sel_q   <= 1'b0;
         rd_oor_q   <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_fire;
         if (rd_fire) begin
            rd_sel_q <= bank_sel;
            rd_oor_q <= ~rd_ok;
         end
         if (init_done) begin
            bank_sel   <= 1'b0;
            addr_err_q <= 1'b0;
         end else begin
            if (swap_fire) bank_sel <= ~bank_sel;
            if ((rd_fire & ~rd_ok) | (wr_fire & ~wr_ok)) addr_err_q <= 1'b1;
         end
      end
   end

   // Each bank's read register holds between reads, so the steered output holds too.
   assign bus.rd_data  = rd_oor_q ? '0 : b_rd_data[rd_sel_q];
   assign bus.rd_valid = rd_valid_q;
   assign bus.bank_sel = bank_sel;
   assign bus.busy     = busy;
   assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_lbm_dist_pingpong_ram.sv
// tb/tb_lbm_dist_pingpong_ram.sv - directed self-checking bench for lbm_dist_pingpong_ram
module tb_lbm_dist_pingpong_ram;
   import lbm_pkg::*;

   logic Clk = 1'b0;
   logic Reset = 1'b1;
   always #5 Clk = ~Clk;

   lbm_dist_pingpong_ram_if #(.ADDR_W(4)) b4 ();
   lbm_dist_pingpong_ram_if #(.ADDR_W(4)) b3 ();

   lbm_dist_pingpong_ram #(.NX(4), .NY(4)) dut4 (.Clk(Clk), .Reset(Reset), .bus(b4));
   lbm_dist_pingpong_ram #(.NX(3), .NY(3)) dut3 (.Clk(Clk), .Reset(Reset), .bus(b3));

   int n_pass = 0;
   int n_total = 0;

   typedef struct {
      logic       wr_en;
      logic [3:0] wr_addr;
      logic [8:0] mask;
      node_vec_t  wr_data;
      logic       swap;
      logic       rd_en;
      logic [3:0] rd_addr;
      logic       exp_valid;
      logic       exp_sel;
      logic       chk_data;
      node_vec_t  exp_data;
   } vec_t;

   localparam int NV = 21;
   vec_t tbl [NV];

   function automatic node_vec_t mk_vec(input int base, input int step);
      node_vec_t v;
      for (int i = 0; i < Q; i++) v[i] = dist_t'(base + i * step);
      return v;
   endfunction

   function automatic vec_t mkv(input logic we, input int wa, input int m, input node_vec_t wd,
                                input logic sw, input logic re, input int ra,
                                input logic ev, input logic es, input logic cd, input node_vec_t ed);
      vec_t v;
      v.wr_en = we; v.wr_addr = 4'(wa); v.mask = 9'(m); v.wr_data = wd;
      v.swap = sw; v.rd_en = re; v.rd_addr = 4'(ra);
      v.exp_valid = ev; v.exp_sel = es; v.chk_data = cd; v.exp_data = ed;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic check_vec(input string name, input node_vec_t got, input node_vec_t exp);
      n_total++;
      if (got === exp) n_pass++;
      else begin
         for (int i = 0; i < Q; i++) begin
            if (got[i] !== exp[i]) begin
               $display("FAIL %s: lane %0d got %0d expected %0d", name, i, got[i], exp[i]);
               break;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle_all();
      b4.rd_en = 0; b4.wr_en = 0; b4.swap = 0; b4.init_start = 0;
      b3.rd_en = 0; b3.wr_en = 0; b3.swap = 0; b3.init_start = 0;
   endtask

   task automatic drive4(input vec_t v);
      b4.wr_en = v.wr_en; b4.wr_addr = v.wr_addr; b4.wr_lane_mask = v.mask; b4.wr_data = v.wr_data;
      b4.swap = v.swap; b4.rd_en = v.rd_en; b4.rd_addr = v.rd_addr;
   endtask

   task automatic wr3(input int a, input node_vec_t d);
      b3.wr_en = 1; b3.wr_addr = 4'(a); b3.wr_lane_mask = '1; b3.wr_data = d;
      step();
      idle_all();
   endtask

   task automatic rd3(input int a);
      b3.rd_en = 1; b3.rd_addr = 4'(a);
      step();
      idle_all();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      node_vec_t z, m1, t5, e7;
      int busy_cnt;
      logic rv_seen;

      z = '0;
      m1 = mk_vec(-1, 0);
      t5 = mk_vec(55, 0); t5[2] = 7;
      e7 = mk_vec(-1, 0); e7[2] = 7;

      //       we wa  mask    data            sw re ra ev es cd exp
      tbl[0]  = mkv(1, 5, 'h1FF, mk_vec(1, 1),  0, 0, 0, 0, 0, 0, z);
      tbl[1]  = mkv(0, 0, 0,     z,             1, 0, 0, 0, 1, 0, z);
      tbl[2]  = mkv(0, 0, 0,     z,             0, 1, 5, 1, 1, 1, mk_vec(1, 1));
      tbl[3]  = mkv(0, 0, 0,     z,             0, 0, 0, 0, 1, 1, mk_vec(1, 1));
      tbl[4]  = mkv(1, 3, 'h1FF, m1,            0, 0, 0, 0, 1, 0, z);
      tbl[5]  = mkv(1, 3, 'h004, t5,            0, 0, 0, 0, 1, 0, z);
      tbl[6]  = mkv(0, 0, 0,     z,             1, 0, 0, 0, 0, 0, z);
      tbl[7]  = mkv(0, 0, 0,     z,             0, 1, 3, 1, 0, 1, e7);
      tbl[8]  = mkv(1, 0, 'h1FF, mk_vec(11, 0), 0, 0, 0, 0, 0, 0, z);
      tbl[9]  = mkv(0, 0, 0,     z,             1, 0, 0, 0, 1, 0, z);
      tbl[10] = mkv(1, 0, 'h1FF, mk_vec(22, 0), 0, 0, 0, 0, 1, 0, z);
      tbl[11] = mkv(0, 0, 0,     z,             1, 1, 0, 1, 0, 1, mk_vec(11, 0));
      tbl[12] = mkv(0, 0, 0,     z,             0, 1, 0, 1, 0, 1, mk_vec(22, 0));
      tbl[13] = mkv(0, 0, 0,     z,             1, 0, 0, 0, 1, 0, z);
      tbl[14] = mkv(0, 0, 0,     z,             1, 0, 0, 0, 0, 0, z);
      tbl[15] = mkv(1, 7, 'h1FF, mk_vec(33, 0), 1, 0, 0, 0, 1, 0, z);
      tbl[16] = mkv(0, 0, 0,     z,             0, 1, 7, 1, 1, 1, mk_vec(33, 0));
      tbl[17] = mkv(0, 0, 0,     z,             1, 0, 0, 0, 0, 0, z);
      tbl[18] = mkv(1, 5, 'h000, mk_vec(99, 0), 0, 0, 0, 0, 0, 0, z);
      tbl[19] = mkv(0, 0, 0,     z,             1, 0, 0, 0, 1, 0, z);
      tbl[20] = mkv(0, 0, 0,     z,             0, 1, 5, 1, 1, 1, mk_vec(1, 1));

      idle_all();
      b4.rd_addr = 0; b4.wr_addr = 0; b4.wr_lane_mask = 0; b4.wr_data = '0; b4.init_data = '0;
      b3.rd_addr = 0; b3.wr_addr = 0; b3.wr_lane_mask = 0; b3.wr_data = '0; b3.init_data = '0;

      // Reset
      Reset = 1;
      step(); step();
      @(negedge Clk);
      Reset = 0;
      step();
      check("rst_rd_valid", 32'(b4.rd_valid), 0);
      check("rst_bank_sel", 32'(b4.bank_sel), 0);
      check("rst_busy", 32'(b4.busy), 0);
      check("rst_addr_err", 32'(b4.addr_err), 0);
      check_vec("rst_rd_data", b4.rd_data, z);
      check("rst3_addr_err", 32'(b3.addr_err), 0);

      // Out-of-range on DEPTH=9
      rd3(12);
      check("oor_rd_valid", 32'(b3.rd_valid), 1);
      check_vec("oor_rd_data0", b3.rd_data, z);
      check("oor_rd_err", 32'(b3.addr_err), 1);
      @(negedge Clk); Reset = 1;
      #1 check("oor_err_cleared_by_reset", 32'(b3.addr_err), 0);
      @(negedge Clk); Reset = 0;
      step();
      wr3(4, mk_vec(68, 0));
      wr3(8, mk_vec(136, 0));
      check("oor_edge_no_err", 32'(b3.addr_err), 0);
      wr3(12, mk_vec(119, 0));
      check("oor_wr_err", 32'(b3.addr_err), 1);
      b3.swap = 1; step(); idle_all();
      check("oor_swap_sel", 32'(b3.bank_sel), 1);
      rd3(4);
      check_vec("oor_addr4_kept", b3.rd_data, mk_vec(68, 0));
      rd3(12);
      check("oor_rd12_valid", 32'(b3.rd_valid), 1);
      check_vec("oor_rd12_zero", b3.rd_data, z);
      rd3(8);
      check_vec("oor_addr8", b3.rd_data, mk_vec(136, 0));
      check("oor_err_sticky", 32'(b3.addr_err), 1);

      // Table-driven write/swap/read/mask on DEPTH=16
      for (int k = 0; k < NV; k++) begin
         drive4(tbl[k]);
         step();
         idle_all();
         check($sformatf("v%0d_rd_valid", k), 32'(b4.rd_valid), 32'(tbl[k].exp_valid));
         check($sformatf("v%0d_bank_sel", k), 32'(b4.bank_sel), 32'(tbl[k].exp_sel));
         if (tbl[k].chk_data) check_vec($sformatf("v%0d_rd_data", k), b4.rd_data, tbl[k].exp_data);
      end
      check("tbl_addr_err", 32'(b4.addr_err), 0);

`ifdef LBM_DIST_INIT_EN
      b4.init_data = mk_vec(100, 1); b4.init_start = 1;
      step();
      idle_all();
      busy_cnt = 0; rv_seen = 0;
      while (b4.busy && busy_cnt < 40) begin
         busy_cnt++;
         if (b4.rd_valid) rv_seen = 1;
         b4.rd_en = 1; b4.rd_addr = 1; b4.swap = 1; b4.init_start = 1; b4.init_data = mk_vec(-9, 0);
         b4.wr_en = 1; b4.wr_addr = 2; b4.wr_lane_mask = '1; b4.wr_data = mk_vec(-5, 0);
         step();
      end
      idle_all();
      check("init_busy_cycles", 32'(busy_cnt), 16);
      check("init_no_rd_valid", 32'(rv_seen), 0);
      check("init_busy_low", 32'(b4.busy), 0);
      check("init_bank_sel", 32'(b4.bank_sel), 0);
      check("init_rd_valid_after", 32'(b4.rd_valid), 0);
      for (int bk = 0; bk < 2; bk++) begin
         for (int a = 0; a < 16; a++) begin
            b4.rd_en = 1; b4.rd_addr = 4'(a);
            step();
            idle_all();
            check_vec($sformatf("init_b%0d_a%0d", bk, a), b4.rd_data, mk_vec(100, 1));
         end
         b4.swap = 1; step(); idle_all();
      end
      b4.init_start = 1; step(); idle_all();
      step(); step(); step();
      check("init2_busy", 32'(b4.busy), 1);
      #2 Reset = 1;
      #1 check("init_reset_busy", 32'(b4.busy), 0);
      @(negedge Clk); Reset = 0;
      step();
      check("init_reset_busy_after", 32'(b4.busy), 0);
      check("init_reset_bank_sel", 32'(b4.bank_sel), 0);
`else
      b4.init_start = 1; b4.init_data = mk_vec(100, 1);
      b4.rd_en = 1; b4.rd_addr = 7;
      step();
      idle_all();
      check("noinit_busy", 32'(b4.busy), 0);
      check("noinit_rd_valid", 32'(b4.rd_valid), 1);
      check_vec("noinit_rd_data", b4.rd_data, mk_vec(33, 0));
      step();
      check("noinit_busy2", 32'(b4.busy), 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
